blinds_motor_ctrl: RTL and testbench

//  Sequencer for the electric roller blinds. Accepts a requested open level
//  (0=closed, 1=quarter, 2=half, 3=fully open) and drives the motor up/down.

---
 rtl/blinds_motor_ctrl.sv | 154 +++++++++++++++
 tb/tb_blinds_motor_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/blinds_motor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : blinds_motor_ctrl
// Purpose  : Roller-blind level sequencer: moves the motor, settles, commits the
//            level. Optional BLINDS_OBSTRUCT_EN adds obstruct/err abort.
// Revision : 1.0  initial release
// ============================================================================
module blinds_motor_ctrl #(
    parameter int unsigned STEPS_PER_LEVEL = 16,
    parameter int unsigned SETTLE_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [1:0] req_level,
    output logic       req_ready,
    output logic       motor_up,
    output logic       motor_down,
    output logic [1:0] level,
    output logic       sel_a,
    output logic       sel_b,
    output logic       busy,
`ifdef BLINDS_OBSTRUCT_EN
    input  logic       obstruct,
    output logic       err,
`endif
    output logic       done
);

    localparam int unsigned POS_W = $clog2(3 * STEPS_PER_LEVEL + 1);
    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MOVE_UP   = 3'd1,
        ST_MOVE_DOWN = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    state_t             state_q;
    logic [POS_W-1:0]   pos_q;
    logic [1:0]         target_q;
    logic [1:0]         level_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               motor_up_q;
    logic               motor_down_q;
    logic               done_q;
`ifdef BLINDS_OBSTRUCT_EN
    logic               err_q;
`endif

    logic [POS_W-1:0]   pos_up_d;
    logic [POS_W-1:0]   pos_dn_d;
    logic [POS_W-1:0]   tgt_pos;

    assign pos_up_d = pos_q + 1'b1;
    assign pos_dn_d = pos_q - 1'b1;
    assign tgt_pos  = POS_W'(target_q) * POS_W'(STEPS_PER_LEVEL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pos_q        <= '0;
            target_q     <= 2'd0;
            level_q      <= 2'd0;
            cnt_q        <= '0;
            motor_up_q   <= 1'b0;
            motor_down_q <= 1'b0;
            done_q       <= 1'b0;
`ifdef BLINDS_OBSTRUCT_EN
            err_q        <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef BLINDS_OBSTRUCT_EN
            err_q  <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        target_q <= req_level;
                        if (req_level > level_q) begin
                            state_q    <= ST_MOVE_UP;
                            motor_up_q <= 1'b1;
                        end else if (req_level < level_q) begin
                            state_q      <= ST_MOVE_DOWN;
                            motor_down_q <= 1'b1;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_MOVE_UP: begin
                    pos_q <= pos_up_d;
                    if (pos_up_d == tgt_pos) begin
                        state_q    <= ST_SETTLE;
                        motor_up_q <= 1'b0;
                    end
                end
                ST_MOVE_DOWN: begin
                    pos_q <= pos_dn_d;
`ifdef BLINDS_OBSTRUCT_EN
                    // Abort: the step just taken still counts, then retreat to the committed level.
                    if (obstruct) begin
                        target_q     <= level_q;
                        state_q      <= ST_MOVE_UP;
                        motor_down_q <= 1'b0;
                        motor_up_q   <= 1'b1;
                        err_q        <= 1'b1;
                    end else
`endif
                    if (pos_dn_d == tgt_pos) begin
                        state_q      <= ST_SETTLE;
                        motor_down_q <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    level_q <= target_q;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    motor_up_q   <= 1'b0;
                    motor_down_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign motor_up   = motor_up_q;
    assign motor_down = motor_down_q;
    assign level      = level_q;
    assign sel_a      = level_q[1];
    assign sel_b      = level_q[0];
    assign done       = done_q;
`ifdef BLINDS_OBSTRUCT_EN
    assign err        = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_blinds_motor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_blinds_motor_ctrl
// Purpose  : Directed self-checking bench for blinds_motor_ctrl (STEPS=4, SETTLE=2).
// Revision : 1.0  initial release
// ============================================================================
module tb_blinds_motor_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [1:0] req_level;
    logic       req_ready, motor_up, motor_down, sel_a, sel_b, busy, done;
    logic [1:0] level;
    logic       obstruct;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    blinds_motor_ctrl #(
        .STEPS_PER_LEVEL(4),
        .SETTLE_CYCLES  (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_level (req_level),
        .req_ready (req_ready),
        .motor_up  (motor_up),
        .motor_down(motor_down),
        .level     (level),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .busy      (busy),
`ifdef BLINDS_OBSTRUCT_EN
        .obstruct  (obstruct),
        .err       (err),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one request for a single cycle; returns at the sampling point of the next cycle.
    task automatic request(input logic [1:0] lv);
        req_level = lv;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic run_until_done(input int budget, input int pulse_at, input logic [1:0] lvl0,
                                  output int up_c, output int dn_c, output int gap_c,
                                  output int cyc, output bit seen, output bit both,
                                  output bit lvl_moved);
        up_c = 0; dn_c = 0; gap_c = 0; cyc = -1; seen = 0; both = 0; lvl_moved = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (motor_up && motor_down) both = 1;
            if (level !== lvl0) lvl_moved = 1;
            if (motor_up) up_c++;
            if (motor_down) dn_c++;
            if (done) begin
                seen = 1;
                cyc  = i;
            end else if (!motor_up && !motor_down) begin
                gap_c++;
            end
            if (i == pulse_at) begin
                req_level = 2'd0;
                req_valid = 1'b1;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    int up_c, dn_c, gap_c, cyc;
    bit seen, both, lvl_moved;

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_level = 2'd0;
        obstruct  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_level", level, 2'd0);
        chk("rst_sel_a", sel_a, 1'b0);
        chk("rst_sel_b", sel_b, 1'b0);
        chk("rst_up", motor_up, 1'b0);
        chk("rst_down", motor_down, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ready", req_ready, 1'b1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 1'b0);

        // 0 -> 3
        request(2'd3);
        chk("t2_busy", busy, 1'b1);
        chk("t2_ready", req_ready, 1'b0);
        run_until_done(100, -1, 2'd0, up_c, dn_c, gap_c, cyc, seen, both, lvl_moved);
        chk("t2_seen", seen, 1'b1);
        chk("t2_up_cycles", up_c, 12);
        chk("t2_down_cycles", dn_c, 0);
        chk("t2_settle", gap_c, 2);
        chk("t2_both", both, 1'b0);
        chk("t2_lvl_stable", lvl_moved, 1'b0);
        chk("t2_level", level, 2'd3);
        chk("t2_sel_a", sel_a, 1'b1);
        chk("t2_sel_b", sel_b, 1'b1);
        chk("t2_done_pulse", done, 1'b0);
        chk("t2_ready_after", req_ready, 1'b1);

        // 3 -> 1, with a request to 0 pulsed mid-move
        request(2'd1);
        run_until_done(100, 3, 2'd3, up_c, dn_c, gap_c, cyc, seen, both, lvl_moved);
        chk("t3_seen", seen, 1'b1);
        chk("t3_down_cycles", dn_c, 8);
        chk("t3_up_cycles", up_c, 0);
        chk("t3_settle", gap_c, 2);
        chk("t3_lvl_stable", lvl_moved, 1'b0);
        chk("t3_level", level, 2'd1);
        chk("t3_sel_a", sel_a, 1'b0);
        chk("t3_sel_b", sel_b, 1'b1);
        repeat (3) @(negedge clk);
        chk("t3_ignored_busy", busy, 1'b0);
        chk("t3_ignored_level", level, 2'd1);

        // 1 -> 2, then 2 -> 2 (no motion)
        request(2'd2);
        run_until_done(100, -1, 2'd1, up_c, dn_c, gap_c, cyc, seen, both, lvl_moved);
        chk("t4_pre_up_cycles", up_c, 4);
        chk("t4_pre_level", level, 2'd2);
        request(2'd2);
        run_until_done(100, -1, 2'd2, up_c, dn_c, gap_c, cyc, seen, both, lvl_moved);
        chk("t4_seen", seen, 1'b1);
        chk("t4_done_next_cycle", cyc, 0);
        chk("t4_motor", up_c + dn_c, 0);
        chk("t4_level", level, 2'd2);
        chk("t4_sel_a", sel_a, 1'b1);
        chk("t4_sel_b", sel_b, 1'b0);

        // Back to 0, then 0 -> 3 interrupted by reset after 5 motor cycles
        request(2'd0);
        run_until_done(100, -1, 2'd2, up_c, dn_c, gap_c, cyc, seen, both, lvl_moved);
        chk("t5_pre_level", level, 2'd0);
        request(2'd3);
        repeat (4) @(negedge clk);
        chk("t5_moving", motor_up, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_up", motor_up, 1'b0);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_ready", req_ready, 1'b1);
        chk("t5_rst_level", level, 2'd0);
        chk("t5_rst_sel", {sel_a, sel_b}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        request(2'd1);
        run_until_done(100, -1, 2'd0, up_c, dn_c, gap_c, cyc, seen, both, lvl_moved);
        chk("t5_up_cycles", up_c, 4);
        chk("t5_level", level, 2'd1);

`ifdef BLINDS_OBSTRUCT_EN
        // 1 -> 2, then 2 -> 0 obstructed after 3 down cycles
        request(2'd2);
        run_until_done(100, -1, 2'd1, up_c, dn_c, gap_c, cyc, seen, both, lvl_moved);
        chk("t6_pre_level", level, 2'd2);
        request(2'd0);
        chk("t6_down1", motor_down, 1'b1);
        @(negedge clk);
        chk("t6_down2", motor_down, 1'b1);
        @(negedge clk);
        chk("t6_down3", motor_down, 1'b1);
        obstruct = 1'b1;
        @(negedge clk);
        obstruct = 1'b0;
        chk("t6_err", err, 1'b1);
        chk("t6_down_off", motor_down, 1'b0);
        run_until_done(100, -1, 2'd2, up_c, dn_c, gap_c, cyc, seen, both, lvl_moved);
        chk("t6_seen", seen, 1'b1);
        chk("t6_up_cycles", up_c, 3);
        chk("t6_down_after", dn_c, 0);
        chk("t6_err_cleared", err, 1'b0);
        chk("t6_level", level, 2'd2);
        chk("t6_sel_a", sel_a, 1'b1);
        chk("t6_sel_b", sel_b, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
